// File: rtl/skolem_sweep_ctrl_if.sv
// Link between the sweep controller and the combinational Skolem block it exercises:
// the applied input vector, the block's output and the golden output for that vector.
interface skolem_sweep_ctrl_if #(
  parameter int unsigned N_IN = 8
);
  logic [N_IN-1:0] sk_vec;
  logic            sk_out;
  logic            ref_out;

  modport master (output sk_vec, input sk_out, input ref_out);
  modport slave  (input sk_vec, output sk_out, output ref_out);
endinterface

// File: rtl/skolem_sweep_ctrl.sv
// Exhaustive sweep of all 2^N_IN input vectors through a Skolem block, counting ones.
// Golden-output comparison is compiled in only when SKOLEM_SWEEP_CHECK_EN is defined.
module skolem_sweep_ctrl #(
  parameter int unsigned N_IN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  skolem_sweep_ctrl_if.master sk,
  output logic                busy,
  output logic                done,
  output logic [N_IN:0]       ones_cnt,
  output logic                mism,
  output logic [N_IN-1:0]     mism_vec,
  output logic [N_IN:0]       mism_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e          state_q;
  logic [N_IN-1:0] vec_q;
  logic [N_IN-1:0] t_q;
  logic            s_sk_q;
  logic            v_q;
  logic [N_IN:0]   ones_q;

  logic abort_now;
  logic acc;
  logic accept;

  assign abort_now = abort && ((state_q == StRun) || (state_q == StDrain));
  // An abort discards the pending sample instead of accumulating it.
  assign acc       = v_q && !abort_now;
  assign accept    = (state_q == StIdle) && start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      t_q     <= '0;
      s_sk_q  <= 1'b0;
      v_q     <= 1'b0;
      ones_q  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      v_q  <= 1'b0;
      if (acc) begin
        ones_q <= ones_q + (N_IN+1)'(s_sk_q);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            busy    <= 1'b1;
            vec_q   <= '0;
            ones_q  <= '0;
          end
        end
        StRun: begin
          if (abort) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            vec_q   <= '0;
          end else begin
            v_q    <= 1'b1;
            s_sk_q <= sk.sk_out;
            t_q    <= vec_q;
            // Hold all-ones after the last vector rather than wrapping.
            if (vec_q == '1) begin
              state_q <= StDrain;
            end else begin
              vec_q <= vec_q + 1'b1;
            end
          end
        end
        StDrain: begin
          busy <= 1'b0;
          if (abort) begin
            state_q <= StIdle;
            vec_q   <= '0;
          end else begin
            state_q <= StDone;
            done    <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          vec_q   <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign sk.sk_vec = vec_q;
  assign ones_cnt  = ones_q;

`ifdef SKOLEM_SWEEP_CHECK_EN
  logic            s_ref_q;
  logic            mism_q;
  logic [N_IN-1:0] mism_vec_q;
  logic [N_IN:0]   mism_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_ref_q    <= 1'b0;
      mism_q     <= 1'b0;
      mism_vec_q <= '0;
      mism_cnt_q <= '0;
    end else if (accept) begin
      mism_q     <= 1'b0;
      mism_vec_q <= '0;
      mism_cnt_q <= '0;
    end else begin
      if (state_q == StRun) begin
        s_ref_q <= sk.ref_out;
      end
      if (acc && (s_sk_q != s_ref_q)) begin
        mism_cnt_q <= mism_cnt_q + 1'b1;
        if (!mism_q) begin
          mism_q     <= 1'b1;
          mism_vec_q <= t_q;
        end
      end
    end
  end

  assign mism     = mism_q;
  assign mism_vec = mism_vec_q;
  assign mism_cnt = mism_cnt_q;
`else
  logic unused_chk;
  assign unused_chk = sk.ref_out ^ (^t_q) ^ accept;
  assign mism       = 1'b0;
  assign mism_vec   = '0;
  assign mism_cnt   = '0;
`endif

endmodule
